// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store initiator.
// Pipeline requests of byte, halfword or word size at any byte alignment
// become one or two word-aligned accesses on a synchronous-read,
// byte-enabled data memory. Store data is moved onto its byte lanes. Load
// data is reassembled little-endian and then zero- or sign-extended.
// Every output is driven straight from a register.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  memop,
    input  logic        loadSignExt,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // Size codes shared with the decoder. Any other code is treated as word.
    localparam logic [1:0] MEMOP_BYTE     = 2'b00;
    localparam logic [1:0] MEMOP_HALFWORD = 2'b01;
    localparam logic [1:0] MEMOP_WORD     = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_FIN  = 2'b11
    } state_t;

    // Eight-lane byte mask. Lanes 3:0 belong to the first word and lanes 7:4
    // to the following word.
    function automatic logic [7:0] lane_mask(input logic [1:0] op, input logic [1:0] off);
        logic [7:0] base;
        case (op)
            MEMOP_BYTE:     base = 8'h01;
            MEMOP_HALFWORD: base = 8'h03;
            MEMOP_WORD:     base = 8'h0F;
            default:        base = 8'h0F;
        endcase
        return base << off;
    endfunction

    // Picks the low bytes of {hi,lo} >> 8*off, then extends the value to 32 bits.
    function automatic logic [31:0] load_extract(input logic [1:0] op, input logic sext,
                                                 input logic [1:0] off,
                                                 input logic [31:0] hi, input logic [31:0] lo);
        logic [5:0]  sh;
        logic [31:0] w;
        sh = {1'b0, off, 3'b000};
        w  = (lo >> sh) | (hi << (6'd32 - sh));
        case (op)
            MEMOP_BYTE:     return {{24{sext & w[7]}}, w[7:0]};
            MEMOP_HALFWORD: return {{16{sext & w[15]}}, w[15:0]};
            MEMOP_WORD:     return w;
            default:        return w;
        endcase
    endfunction

    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_memop;
    logic        r_sext;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_lo;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_stall;
    logic [31:0] r_mem_addr;
    logic        r_mem_re;
    logic        r_mem_we;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;

    state_t      w_next;
    logic [1:0]  w_mask_op;
    logic [1:0]  w_mask_off;
    logic [7:0]  w_mask;
    logic        w_split;
    logic [31:0] w_word_addr;
    logic [5:0]  w_hi_sh;
    logic [31:0] w_ld_lo;
    logic [31:0] w_ld_hi;
    logic [31:0] w_mem_addr_n;
    logic        w_mem_re_n;
    logic        w_mem_we_n;
    logic [3:0]  w_mem_be_n;
    logic [31:0] w_mem_wdata_n;

    // One mask computation serves both cases. In IDLE it uses the incoming
    // request; in every other state it uses the latched request.
    always_comb begin
        w_mask_op  = r_memop;
        w_mask_off = r_addr[1:0];
        if (r_state == ST_IDLE) begin
            w_mask_op  = memop;
            w_mask_off = addr[1:0];
        end else begin
            w_mask_op  = r_memop;
            w_mask_off = r_addr[1:0];
        end
        w_mask      = lane_mask(w_mask_op, w_mask_off);
        w_split     = |w_mask[7:4];
        w_word_addr = {r_addr[31:2], 2'b00};
        w_hi_sh     = 6'd32 - {1'b0, r_addr[1:0], 3'b000};
    end

    // Selects the two words used for load reassembly. An unsplit load has
    // its only word on the read bus in FIN.
    always_comb begin
        w_ld_lo = mem_rdata;
        w_ld_hi = 32'h0000_0000;
        if (w_split) begin
            w_ld_lo = r_lo;
            w_ld_hi = mem_rdata;
        end else begin
            w_ld_lo = mem_rdata;
            w_ld_hi = 32'h0000_0000;
        end
    end

    // Next state, and the memory-side values for the cycle that follows it.
    always_comb begin
        w_next        = r_state;
        w_mem_addr_n  = 32'h0000_0000;
        w_mem_re_n    = 1'b0;
        w_mem_we_n    = 1'b0;
        w_mem_be_n    = 4'h0;
        w_mem_wdata_n = 32'h0000_0000;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_next        = ST_ACC0;
                    w_mem_addr_n  = {addr[31:2], 2'b00};
                    w_mem_be_n    = w_mask[3:0];
                    w_mem_wdata_n = wdata << {addr[1:0], 3'b000};
                    w_mem_re_n    = ~we;
                    w_mem_we_n    = we;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ACC0: begin
                if (w_split) begin
                    w_next        = ST_ACC1;
                    w_mem_addr_n  = w_word_addr + 32'd4;
                    w_mem_be_n    = w_mask[7:4];
                    w_mem_wdata_n = r_wdata >> w_hi_sh;
                    w_mem_re_n    = ~r_we;
                    w_mem_we_n    = r_we;
                end else begin
                    w_next = ST_FIN;
                end
            end
            ST_ACC1: w_next = ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register and the registered control and memory outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b0;
            r_stall     <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'h0;
            r_mem_wdata <= 32'h0000_0000;
        end else begin
            r_state     <= w_next;
            r_done      <= (r_state == ST_FIN);
            r_stall     <= (w_next != ST_IDLE);
            r_mem_addr  <= w_mem_addr_n;
            r_mem_re    <= w_mem_re_n;
            r_mem_we    <= w_mem_we_n;
            r_mem_be    <= w_mem_be_n;
            r_mem_wdata <= w_mem_wdata_n;
        end
    end

    // Latches the request and collects load data. On reset the partial
    // buffer and the result are cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_memop <= 2'b00;
            r_sext  <= 1'b0;
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
            r_lo    <= 32'h0000_0000;
            r_rdata <= 32'h0000_0000;
        end else begin
            if (r_state == ST_IDLE && req) begin
                r_we    <= we;
                r_memop <= memop;
                r_sext  <= loadSignExt;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (r_state == ST_ACC1) begin
                r_lo <= mem_rdata;
            end
            if (r_state == ST_FIN && !r_we) begin
                r_rdata <= load_extract(r_memop, r_sext, r_addr[1:0], w_ld_hi, w_ld_lo);
            end
        end
    end

    assign rdata     = r_rdata;
    assign done      = r_done;
    assign stall     = r_stall;
    assign mem_addr  = r_mem_addr;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small synchronous byte-enabled memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst, req, we, loadSignExt;
    logic [1:0]  memop;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        done, stall;
    logic [31:0] mem_addr;
    logic        mem_re, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_bad = 0;

    // Memory: 256 words indexed by address bits [9:2]. Preloads use pre_*.
    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [31:0] pre_a  = 32'h0;
    logic [31:0] pre_v  = 32'h0;

    // Accesses observed during the most recent request.
    logic [31:0] acc_addr [0:3];
    logic [3:0]  acc_be   [0:3];
    logic [31:0] acc_wd   [0:3];
    logic        acc_re   [0:3];
    int          n_acc;
    int          cyc;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .memop(memop),
        .loadSignExt(loadSignExt), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .stall(stall),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_a[9:2]] <= pre_v;
        end else if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
        if (mem_re) mem_rdata <= mem[mem_addr[9:2]];
        else        mem_rdata <= 32'h5A5A_A5A5;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        pre_en = 1'b1; pre_a = a; pre_v = v;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic record();
        if (mem_re || mem_we) begin
            if (n_acc < 4) begin
                acc_addr[n_acc] = mem_addr;
                acc_be[n_acc]   = mem_be;
                acc_wd[n_acc]   = mem_wdata;
                acc_re[n_acc]   = mem_re;
            end
            n_acc++;
        end
    endtask

    // Presents one request and runs it to its done cycle. cyc counts the
    // cycles after the accepting edge, including the done cycle.
    task automatic run_access(input logic w, input logic [1:0] op, input logic sx,
                              input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; memop = op; loadSignExt = sx; addr = a; wdata = d;
        tick();
        req = 1'b0;
        n_acc = 0;
        cyc = 1;
        record();
        while (!done && cyc < 12) begin
            tick();
            cyc++;
            record();
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; memop = 2'b10; loadSignExt = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        tick(); tick();
        rst = 1'b0;
        // Reset values
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_strobes", {30'h0, mem_re, mem_we}, 32'h0);
        chk("rst_be", {28'h0, mem_be}, 32'h0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_mwdata", mem_wdata, 32'h0);

        // 1. Aligned word store, then load it back
        run_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        chk("st_w_cycles", cyc, 32'd3);
        chk("st_w_nacc", n_acc, 32'd1);
        chk("st_w_addr", acc_addr[0], 32'h10);
        chk("st_w_be", {28'h0, acc_be[0]}, 32'hF);
        chk("st_w_wd", acc_wd[0], 32'hDEADBEEF);
        chk("st_w_re", {31'h0, acc_re[0]}, 32'h0);
        chk("st_w_mem", mem[4], 32'hDEADBEEF);
        run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("ld_w_cycles", cyc, 32'd3);
        chk("ld_w_re", {31'h0, acc_re[0]}, 32'h1);
        chk("ld_w_rdata", rdata, 32'hDEADBEEF);
        tick();
        chk("done_pulse", {31'h0, done}, 32'h0);

        // 2. Byte loads from 0x80FF7F01
        poke(32'h20, 32'h80FF7F01);
        run_access(1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
        chk("lb23s_be", {28'h0, acc_be[0]}, 32'h8);
        chk("lb23s_addr", acc_addr[0], 32'h20);
        chk("lb23s_rdata", rdata, 32'hFFFFFF80);
        run_access(1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
        chk("lb23u_rdata", rdata, 32'h00000080);
        run_access(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
        chk("lb21s_be", {28'h0, acc_be[0]}, 32'h2);
        chk("lb21s_re", {31'h0, acc_re[0]}, 32'h1);
        chk("lb21s_rdata", rdata, 32'h0000007F);

        // 3. Split word load at 0x31
        poke(32'h30, 32'h44332211);
        poke(32'h34, 32'h88776655);
        run_access(1'b0, 2'b10, 1'b0, 32'h31, 32'h0);
        chk("ldsp_cycles", cyc, 32'd4);
        chk("ldsp_nacc", n_acc, 32'd2);
        chk("ldsp_addr0", acc_addr[0], 32'h30);
        chk("ldsp_be0", {28'h0, acc_be[0]}, 32'hE);
        chk("ldsp_addr1", acc_addr[1], 32'h34);
        chk("ldsp_be1", {28'h0, acc_be[1]}, 32'h1);
        chk("ldsp_rdata", rdata, 32'h55443322);

        // 4. Split halfword store at 0x43
        poke(32'h40, 32'h11111111);
        poke(32'h44, 32'h22222222);
        run_access(1'b1, 2'b01, 1'b0, 32'h43, 32'h0000ABCD);
        chk("sth_cycles", cyc, 32'd4);
        chk("sth_addr0", acc_addr[0], 32'h40);
        chk("sth_be0", {28'h0, acc_be[0]}, 32'h8);
        chk("sth_wd0", {24'h0, acc_wd[0][31:24]}, 32'hCD);
        chk("sth_addr1", acc_addr[1], 32'h44);
        chk("sth_be1", {28'h0, acc_be[1]}, 32'h1);
        chk("sth_wd1", {24'h0, acc_wd[1][7:0]}, 32'hAB);
        chk("sth_mem40", mem[16], 32'hCD111111);
        chk("sth_mem44", mem[17], 32'h222222AB);
        chk("sth_rdata_kept", rdata, 32'h55443322);

        // 5. Reset during ACC1 of a split load
        req = 1'b1; we = 1'b0; memop = 2'b10; loadSignExt = 1'b0; addr = 32'h31;
        tick();
        req = 1'b0;
        chk("rs_acc0_addr", mem_addr, 32'h30);
        tick();
        chk("rs_acc1_addr", mem_addr, 32'h34);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_stall", {31'h0, stall}, 32'h0);
        chk("rs_strobes", {30'h0, mem_re, mem_we}, 32'h0);
        chk("rs_be", {28'h0, mem_be}, 32'h0);
        chk("rs_maddr", mem_addr, 32'h0);
        chk("rs_done", {31'h0, done}, 32'h0);
        chk("rs_rdata", rdata, 32'h0);
        tick();
        chk("rs_no_done", {31'h0, done}, 32'h0);
        run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("rs_after_cycles", cyc, 32'd3);
        chk("rs_after_rdata", rdata, 32'hDEADBEEF);

        // 6. req held high; a wrapping split load is accepted in the done cycle
        poke(32'hFFFFFFFC, 32'hA1B2C3D4);
        poke(32'h0, 32'h11223344);
        req = 1'b1; we = 1'b0; memop = 2'b10; loadSignExt = 1'b0; addr = 32'h10;
        tick();
        addr = 32'hFFFFFFFE;
        tick();
        chk("hold_fin_stall", {31'h0, stall}, 32'h1);
        chk("hold_fin_done", {31'h0, done}, 32'h0);
        tick();
        chk("hold_done", {31'h0, done}, 32'h1);
        chk("hold_rdata0", rdata, 32'hDEADBEEF);
        tick();
        chk("wrap_addr0", mem_addr, 32'hFFFFFFFC);
        chk("wrap_be0", {28'h0, mem_be}, 32'hC);
        chk("wrap_re0", {31'h0, mem_re}, 32'h1);
        chk("wrap_stall", {31'h0, stall}, 32'h1);
        tick();
        req = 1'b0;
        chk("wrap_addr1", mem_addr, 32'h0);
        chk("wrap_be1", {28'h0, mem_be}, 32'h3);
        tick();
        chk("wrap_fin_done", {31'h0, done}, 32'h0);
        tick();
        chk("wrap_done", {31'h0, done}, 32'h1);
        chk("wrap_rdata", rdata, 32'h3344A1B2);
        tick();
        chk("idle_done", {31'h0, done}, 32'h0);
        chk("idle_stall", {31'h0, stall}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
